register_file: RTL and testbench

Four-entry, 8-bit general-purpose register file for the microprocessor datapath. It provides two independent combinational read ports and one synchronous write port. It sits between instruction decode, which supplies register addresses, and the ALU and writeback path, which consume operands and supply results. All entries are writable, including entry 0; there is no hard-wired zero register.

---
 rtl/register_file_pkg.sv | 14 +
 rtl/register_file_if.sv | 26 ++
 rtl/register_file_reg_cell.sv | 21 ++
 rtl/register_file.sv | 45 ++++
 tb/tb_register_file.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared register-file widths, depth, reset value and typedefs.
// Decode and writeback import these as well.
package regfile_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_data_t REG_RESET = reg_data_t'(8'h00);

endpackage : regfile_pkg

// File: rtl/register_file_if.sv
// Register-file access bus: one write port and two combinational read ports.
// The datapath side is the master; the register file is the slave.
interface register_file_if #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
);

  logic              RegWrite;
  logic [ADDR_W-1:0] Read1;
  logic [ADDR_W-1:0] Read2;
  logic [ADDR_W-1:0] WriteR;
  logic [DATA_W-1:0] WriteD;
  logic [DATA_W-1:0] ReadD1;
  logic [DATA_W-1:0] ReadD2;

  modport master (
    output RegWrite, Read1, Read2, WriteR, WriteD,
    input  ReadD1, ReadD2
  );

  modport slave (
    input  RegWrite, Read1, Read2, WriteR, WriteD,
    output ReadD1, ReadD2
  );

endinterface : register_file_if

// File: rtl/register_file_reg_cell.sv
// Single register with asynchronous active-low clear and a load enable.
module reg_cell #(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : reg_cell

// File: rtl/register_file.sv
// Four-entry general-purpose register file: one synchronous write port,
// two combinational read ports, no write-to-read bypass.
module register_file #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic            clk,
  input  logic            reset_n,
  register_file_if.slave  bus
);

  import regfile_pkg::*;

  localparam int unsigned         DEPTH   = 1 << ADDR_W;
  localparam logic [DATA_W-1:0]   RST_VAL = DATA_W'(REG_RESET);

  logic [DEPTH-1:0]  load;
  logic [DATA_W-1:0] q [DEPTH];

  // One-hot write-enable decode.
  always_comb begin
    load = '0;
    if (bus.RegWrite) begin
      load[bus.WriteR] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    reg_cell #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RST_VAL)
    ) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load[i]),
      .d       (bus.WriteD),
      .q       (q[i])
    );
  end

  // Read muxes see stored state only, so a same-address write appears after the edge.
  assign bus.ReadD1 = q[bus.Read1];
  assign bus.ReadD2 = q[bus.Read2];

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random
// traffic compared against an array model of the four registers.
module tb_register_file;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  logic [7:0] model [4];

  register_file_if bus ();

  register_file dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a write at the falling edge, let the rising edge commit it.
  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.RegWrite = 1'b1;
    bus.WriteR   = a;
    bus.WriteD   = d;
    @(posedge clk);
    model[a] = d;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.RegWrite = 1'b0;
    bus.Read1    = 2'd0;
    bus.Read2    = 2'd0;
    bus.WriteR   = 2'd0;
    bus.WriteD   = 8'h00;
    clear_model();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) do_write(2'(i), 8'h5A + 8'(i));
    @(negedge clk);
    bus.RegWrite = 1'b0;
    #2;
    reset_n = 1'b0;
    clear_model();
    for (int a = 0; a < 4; a++) begin
      bus.Read1 = 2'(a);
      bus.Read2 = 2'(3 - a);
      #0.5;
      checks++;
      if (bus.ReadD1 !== 8'h00) begin
        errors++;
        $display("FAIL reset_rd1 addr=%0d got=%h exp=00", a, bus.ReadD1);
      end
      checks++;
      if (bus.ReadD2 !== 8'h00) begin
        errors++;
        $display("FAIL reset_rd2 addr=%0d got=%h exp=00", 3 - a, bus.ReadD2);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sequential_writes();
    do_write(2'd0, 8'hAA);
    do_write(2'd1, 8'hFF);
    do_write(2'd2, 8'h11);
    do_write(2'd3, 8'hAB);
    @(negedge clk);
    bus.RegWrite = 1'b0;
    bus.Read1 = 2'd0; bus.Read2 = 2'd1;
    #1;
    checks++;
    if (bus.ReadD1 !== 8'hAA || bus.ReadD2 !== 8'hFF) begin
      errors++;
      $display("FAIL seq_r0_r1 got=%h/%h exp=aa/ff", bus.ReadD1, bus.ReadD2);
    end
    bus.Read1 = 2'd2; bus.Read2 = 2'd3;
    #1;
    checks++;
    if (bus.ReadD1 !== 8'h11 || bus.ReadD2 !== 8'hAB) begin
      errors++;
      $display("FAIL seq_r2_r3 got=%h/%h exp=11/ab", bus.ReadD1, bus.ReadD2);
    end
    bus.Read1 = 2'd1; bus.Read2 = 2'd1;
    #1;
    checks++;
    if (bus.ReadD1 !== 8'hFF || bus.ReadD2 !== 8'hFF) begin
      errors++;
      $display("FAIL same_addr got=%h/%h exp=ff/ff", bus.ReadD1, bus.ReadD2);
    end
  endtask

  task automatic test_write_disabled();
    @(negedge clk);
    bus.RegWrite = 1'b0;
    bus.WriteR   = 2'd1;
    bus.WriteD   = 8'h55;
    bus.Read1    = 2'd1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.ReadD1 !== 8'hFF) begin
      errors++;
      $display("FAIL write_disabled got=%h exp=ff", bus.ReadD1);
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    bus.Read1    = 2'd2;
    bus.Read2    = 2'd2;
    bus.WriteR   = 2'd2;
    bus.WriteD   = 8'h3C;
    bus.RegWrite = 1'b1;
    #1;
    checks++;
    if (bus.ReadD1 !== 8'h11 || bus.ReadD2 !== 8'h11) begin
      errors++;
      $display("FAIL rdw_before got=%h/%h exp=11/11", bus.ReadD1, bus.ReadD2);
    end
    @(posedge clk);
    model[2] = 8'h3C;
    #1;
    checks++;
    if (bus.ReadD1 !== 8'h3C || bus.ReadD2 !== 8'h3C) begin
      errors++;
      $display("FAIL rdw_after got=%h/%h exp=3c/3c", bus.ReadD1, bus.ReadD2);
    end
    @(negedge clk);
    bus.RegWrite = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    clear_model();
    #1;
    for (int a = 0; a < 4; a++) begin
      bus.Read1 = 2'(a);
      bus.Read2 = 2'(a);
      #0.5;
      checks++;
      if (bus.ReadD1 !== 8'h00 || bus.ReadD2 !== 8'h00) begin
        errors++;
        $display("FAIL midreset addr=%0d got=%h/%h exp=00/00", a, bus.ReadD1, bus.ReadD2);
      end
    end
    bus.RegWrite = 1'b1;
    bus.WriteR   = 2'd1;
    bus.WriteD   = 8'h77;
    bus.Read1    = 2'd1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ReadD1 !== 8'h00) begin
      errors++;
      $display("FAIL write_in_reset got=%h exp=00", bus.ReadD1);
    end
    @(negedge clk);
    bus.RegWrite = 1'b0;
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.ReadD1 !== 8'h00) begin
      errors++;
      $display("FAIL after_release got=%h exp=00", bus.ReadD1);
    end
  endtask

  task automatic test_overwrite();
    do_write(2'd1, 8'h21);
    do_write(2'd2, 8'h42);
    do_write(2'd3, 8'h83);
    do_write(2'd0, 8'h01);
    do_write(2'd0, 8'h02);
    @(negedge clk);
    bus.RegWrite = 1'b0;
    bus.Read1 = 2'd0;
    #1;
    checks++;
    if (bus.ReadD1 !== 8'h02) begin
      errors++;
      $display("FAIL overwrite_r0 got=%h exp=02", bus.ReadD1);
    end
    for (int a = 1; a < 4; a++) begin
      bus.Read2 = 2'(a);
      #1;
      checks++;
      if (bus.ReadD2 !== model[a]) begin
        errors++;
        $display("FAIL overwrite_keep r%0d got=%h exp=%h", a, bus.ReadD2, model[a]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp1;
    logic [7:0] exp2;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus.RegWrite = 1'($urandom_range(0, 1));
      bus.WriteR   = 2'($urandom_range(0, 3));
      bus.WriteD   = 8'($urandom);
      bus.Read1    = 2'($urandom_range(0, 3));
      bus.Read2    = 2'($urandom_range(0, 3));
      #1;
      exp1 = model[bus.Read1];
      exp2 = model[bus.Read2];
      checks++;
      if (bus.ReadD1 !== exp1 || bus.ReadD2 !== exp2) begin
        errors++;
        $display("FAIL rand_pre n=%0d got=%h/%h exp=%h/%h", n, bus.ReadD1, bus.ReadD2, exp1, exp2);
      end
      @(posedge clk);
      if (bus.RegWrite) model[bus.WriteR] = bus.WriteD;
      #1;
      exp1 = model[bus.Read1];
      exp2 = model[bus.Read2];
      checks++;
      if (bus.ReadD1 !== exp1 || bus.ReadD2 !== exp2) begin
        errors++;
        $display("FAIL rand_post n=%0d got=%h/%h exp=%h/%h", n, bus.ReadD1, bus.ReadD2, exp1, exp2);
      end
    end
    @(negedge clk);
    bus.RegWrite = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_sequential_writes();
    test_write_disabled();
    test_read_during_write();
    test_reset_mid_op();
    test_overwrite();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_register_file
